ram_port_arbiter: RTL and testbench
===================================

// Module: ram_port_arbiter
// PURPOSE
//  Shares the single-port 32x2048 word RAM (1-cycle registered read) between the CPU
//  instruction-fetch port (read-only) and data port (read/write). Round-robin grant,
//  byte-to-word address translation, range/alignment checking, waitrequest handshake.
//  Sits between the CPU core bus masters and the RAM instance in the test harness.
// PARAMETERS
//  ADDR_W  11  RAM word-address bits (RAM depth = 2**ADDR_W words)
// PORTS
//  clk            in   1   system clock, all state on posedge
//  rst_n          in   1   asynchronous, active-low reset
//  i_address      in   32  instruction byte address
//  i_read         in   1   instruction read request, held until waitrequest low
//  i_waitrequest  out  1   low for exactly the completing cycle of an instr access
//  i_readdata     out  32  instr read data, valid when i_waitrequest low
//  i_err          out  1   bad address, valid when i_waitrequest low
//  d_address      in   32  data byte address
//  d_read         in   1   data read request
//  d_write        in   1   data write request (wins if d_read also high)
//  d_writedata    in   32  data write value
//  d_waitrequest  out  1   low for exactly the completing cycle of a data access
//  d_readdata     out  32  data read data, valid when d_waitrequest low
//  d_err          out  1   bad address, valid when d_waitrequest low
//  ram_address    out  32  RAM word address, zero-extended addr[ADDR_W+1:2]
//  ram_read       out  1   RAM read strobe
//  ram_write      out  1   RAM write strobe
//  ram_writedata  out  32  RAM write data
//  ram_readdata   in   32  RAM read data, valid cycle after strobe edge
// BEHAVIOUR
//  - FSM: IDLE -> ISSUE -> RESP -> IDLE. 3 cycles per access, no pipelining.
//  - IDLE: if any request, pick winner, latch owner/op/addr/wdata/err -> ISSUE.
//    No request: stay IDLE. ram_read/ram_write low.
//  - Arbitration: single requester wins. Both requesting: the port not in last_grant
//    wins. last_grant updates on every grant; reset value DATA, so first tie -> instr.
//    Worst-case wait for either port = one foreign access (3 cycles) + own 3.
//  - ISSUE: drive latched ram_address/ram_writedata; ram_read or ram_write = 1 for
//    one cycle unless err. err = addr[1:0]!=0 or addr[31:ADDR_W+2]!=0; on err both
//    strobes stay 0 (RAM untouched).
//  - RESP: owner's waitrequest=0; owner readdata = ram_readdata for read, 0 for write
//    or err; owner err = latched err. -> IDLE.
//  - waitrequest=1 for both ports in every other cycle, requesting or not; readdata=0,
//    err=0 outside owner's RESP cycle. Non-owner sees no change during foreign access.
//  - Master dropping request mid-access: access still completes from latched values.
//  - Outputs ram_* are registered/decoded from state only; no comb path from master
//    inputs to RAM or waitrequest outputs.
//  - Reset (async, any state): state=IDLE, last_grant=DATA, ram_read=ram_write=0,
//    ram_address=0, ram_writedata=0, both waitrequest=1, readdata=0, err=0. Write in
//    ISSUE aborted if rst_n falls before its posedge.
// TESTING
//  - Data write 0xDEADBEEF @0x10, then data read @0x10 -> ram_write in cycle 2 with
//    ram_address=4; read returns 0xDEADBEEF, d_waitrequest low on cycle 3 of each.
//  - i_read @0x0 and d_read @0x4 same cycle from reset -> instr served first (RESP
//    cycle 3), data RESP cycle 6; repeat tie -> instr again after data, alternating.
//  - Instr fetch loop held continuously + one d_write -> data completes within 6 cycles.
//  - d_read @0x3 and @0x2000 (ADDR_W=11) -> no RAM strobe, d_err=1, d_readdata=0.
//  - rst_n low during ISSUE of write @0x8 -> ram_write drops immediately, word at
//    RAM[2] keeps old value, waitrequest=1, FSM IDLE on release.
//  - d_read and d_write both high, data 0x12345678 -> treated as write, readdata=0.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - two-master round-robin arbiter in front of a single-port word RAM
//
// Shares one single-port 32-bit x 2**ADDR_W word RAM (1-cycle registered read)
// between the CPU instruction-fetch port (read-only) and the data port
// (read/write). Every access takes exactly three cycles: IDLE (arbitrate and
// latch), ISSUE (RAM strobe), RESP (completion towards the owning master).
//
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   i_address/i_read                 instruction byte address / read request
//   i_waitrequest/i_readdata/i_err   instruction handshake, data, bad-address flag
//   d_address/d_read/d_write         data byte address / read / write request
//   d_writedata                      data write value
//   d_waitrequest/d_readdata/d_err   data handshake, data, bad-address flag
//   ram_address                      RAM word address (zero-extended)
//   ram_read/ram_write               RAM strobes, one ISSUE cycle each
//   ram_writedata                    RAM write data
//   ram_readdata                     RAM read data, valid the cycle after the strobe edge
module ram_port_arbiter #(
  parameter int ADDR_W = 11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_address,
  input  logic        i_read,
  output logic        i_waitrequest,
  output logic [31:0] i_readdata,
  output logic        i_err,
  input  logic [31:0] d_address,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_writedata,
  output logic        d_waitrequest,
  output logic [31:0] d_readdata,
  output logic        d_err,
  output logic [31:0] ram_address,
  output logic        ram_read,
  output logic        ram_write,
  output logic [31:0] ram_writedata,
  input  logic [31:0] ram_readdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  state_t      state;
  logic        owner;
  logic        last_grant;
  logic        op_write;
  logic        acc_err;
  logic        i_wait_q;
  logic        d_wait_q;

  logic        i_req;
  logic        d_req;
  logic        grant_d;
  logic        sel_write;
  logic        sel_err;
  logic [31:0] sel_addr;

  // Arbitration: a lone requester wins; on a tie the port that did not win
  // last time goes next.
  always_comb begin
    i_req     = i_read;
    d_req     = d_read | d_write;
    grant_d   = d_req & (~i_req | (last_grant == OWN_I));
    sel_addr  = grant_d ? d_address : i_address;
    sel_write = grant_d & d_write;
    sel_err   = (sel_addr[1:0] != 2'b00) | (|sel_addr[31:ADDR_W+2]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      owner         <= OWN_I;
      last_grant    <= OWN_D;
      op_write      <= 1'b0;
      acc_err       <= 1'b0;
      ram_address   <= 32'd0;
      ram_writedata <= 32'd0;
      ram_read      <= 1'b0;
      ram_write     <= 1'b0;
      i_wait_q      <= 1'b1;
      d_wait_q      <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_req | d_req) begin
            owner         <= grant_d;
            last_grant    <= grant_d;
            op_write      <= sel_write;
            acc_err       <= sel_err;
            ram_address   <= {{(32-ADDR_W){1'b0}}, sel_addr[ADDR_W+1:2]};
            ram_writedata <= sel_write ? d_writedata : 32'd0;
            // A bad address never reaches the RAM.
            ram_read      <= ~sel_err & ~sel_write;
            ram_write     <= ~sel_err & sel_write;
            state         <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          ram_read  <= 1'b0;
          ram_write <= 1'b0;
          i_wait_q  <= (owner != OWN_I);
          d_wait_q  <= (owner != OWN_D);
          state     <= S_RESP;
        end
        S_RESP: begin
          i_wait_q <= 1'b1;
          d_wait_q <= 1'b1;
          state    <= S_IDLE;
        end
        default: begin
          ram_read  <= 1'b0;
          ram_write <= 1'b0;
          i_wait_q  <= 1'b1;
          d_wait_q  <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

  // Read data is only forwarded to the owner during its RESP cycle, and only
  // for a successful read; RAM output is valid exactly in that cycle.
  assign i_waitrequest = i_wait_q;
  assign d_waitrequest = d_wait_q;
  assign i_readdata    = (!i_wait_q && !op_write && !acc_err) ? ram_readdata : 32'd0;
  assign d_readdata    = (!d_wait_q && !op_write && !acc_err) ? ram_readdata : 32'd0;
  assign i_err         = ~i_wait_q & acc_err;
  assign d_err         = ~d_wait_q & acc_err;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - directed scoreboard bench for ram_port_arbiter
module tb_ram_port_arbiter;

  localparam int ADDR_W = 11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] i_address = 32'd0;
  logic        i_read = 1'b0;
  logic        i_waitrequest;
  logic [31:0] i_readdata;
  logic        i_err;
  logic [31:0] d_address = 32'd0;
  logic        d_read = 1'b0;
  logic        d_write = 1'b0;
  logic [31:0] d_writedata = 32'd0;
  logic        d_waitrequest;
  logic [31:0] d_readdata;
  logic        d_err;
  logic [31:0] ram_address;
  logic        ram_read;
  logic        ram_write;
  logic [31:0] ram_writedata;
  logic [31:0] ram_readdata;

  always #5 clk = ~clk;

  ram_port_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_address    (i_address),
    .i_read       (i_read),
    .i_waitrequest(i_waitrequest),
    .i_readdata   (i_readdata),
    .i_err        (i_err),
    .d_address    (d_address),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_writedata  (d_writedata),
    .d_waitrequest(d_waitrequest),
    .d_readdata   (d_readdata),
    .d_err        (d_err),
    .ram_address  (ram_address),
    .ram_read     (ram_read),
    .ram_write    (ram_write),
    .ram_writedata(ram_writedata),
    .ram_readdata (ram_readdata)
  );

  // Harness RAM: 2048 words, registered read.
  logic [31:0] mem [0:2047];
  logic [31:0] ram_rd_q;
  always @(posedge clk) begin
    if (ram_write) mem[ram_address[10:0]] <= ram_writedata;
    if (ram_read) ram_rd_q <= mem[ram_address[10:0]];
  end
  assign ram_readdata = ram_rd_q;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        iq[$];
  exp_t        dq[$];
  logic [31:0] model [0:2047];
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every completion pops one expectation; outside a completion
  // the port must present zero data and no error.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (!i_waitrequest) begin
        if (iq.size() == 0) chk("i_resp_expected", 32'(iq.size()), 32'd1);
        else begin
          e = iq.pop_front();
          chk("i_readdata", i_readdata, e.data);
          chk("i_err", 32'(i_err), 32'(e.err));
        end
      end else begin
        chk("i_idle_out", {i_readdata[30:0], i_err}, 32'd0);
      end
      if (!d_waitrequest) begin
        if (dq.size() == 0) chk("d_resp_expected", 32'(dq.size()), 32'd1);
        else begin
          e = dq.pop_front();
          chk("d_readdata", d_readdata, e.data);
          chk("d_err", 32'(d_err), 32'(e.err));
        end
      end else begin
        chk("d_idle_out", {d_readdata[30:0], d_err}, 32'd0);
      end
    end
  end

  // One access on one port (port 1 = data), checking cycle timing and strobes.
  task automatic access(input logic port, input logic [31:0] addr, input logic rd,
                        input logic wr, input logic [31:0] wdata, input string tag);
    exp_t        e;
    logic        bad_addr;
    logic        is_wr;
    int          cyc;
    int          scyc;
    int          dcyc;
    logic [31:0] s_addr;
    logic [31:0] s_wd;
    logic        s_wr;
    bad_addr = (addr[1:0] != 2'b00) || (addr[31:13] != 19'd0);
    is_wr    = port & wr;
    e.err    = bad_addr;
    e.data   = (bad_addr || is_wr) ? 32'd0 : model[addr[12:2]];
    if (!bad_addr && is_wr) model[addr[12:2]] = wdata;
    if (port) dq.push_back(e);
    else iq.push_back(e);
    @(posedge clk); #1;
    if (port) begin
      d_address = addr; d_read = rd; d_write = wr; d_writedata = wdata;
    end else begin
      i_address = addr; i_read = 1'b1;
    end
    cyc = 0; scyc = 0; dcyc = 0; s_addr = 32'd0; s_wd = 32'd0; s_wr = 1'b0;
    while (dcyc == 0 && cyc < 12) begin
      @(negedge clk);
      cyc++;
      if (ram_read || ram_write) begin
        scyc = cyc; s_wr = ram_write; s_addr = ram_address; s_wd = ram_writedata;
      end
      if ((port ? d_waitrequest : i_waitrequest) == 1'b0) dcyc = cyc;
    end
    @(posedge clk); #1;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    chk({tag, "_resp_cycle"}, 32'(dcyc), 32'd3);
    if (bad_addr) chk({tag, "_strobe_cycle"}, 32'(scyc), 32'd0);
    else begin
      chk({tag, "_strobe_cycle"}, 32'(scyc), 32'd2);
      chk({tag, "_strobe_is_write"}, 32'(s_wr), 32'(is_wr));
      chk({tag, "_ram_address"}, s_addr, {21'd0, addr[12:2]});
      if (is_wr) chk({tag, "_ram_writedata"}, s_wd, wdata);
    end
  endtask

  // Simultaneous i_read @0x0 and d_read @0x4; checks each port's completion cycle.
  task automatic tie(input string tag, input int exp_i, input int exp_d);
    exp_t e;
    int   cyc;
    int   idone;
    int   ddone;
    e.err = 1'b0;
    e.data = model[0]; iq.push_back(e);
    e.data = model[1]; dq.push_back(e);
    @(posedge clk); #1;
    i_address = 32'h0; i_read = 1'b1; d_address = 32'h4; d_read = 1'b1;
    cyc = 0; idone = 0; ddone = 0;
    while ((idone == 0 || ddone == 0) && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (!i_waitrequest) idone = cyc;
      if (!d_waitrequest) ddone = cyc;
      @(posedge clk); #1;
      if (idone != 0) i_read = 1'b0;
      if (ddone != 0) d_read = 1'b0;
    end
    chk({tag, "_i_resp_cycle"}, 32'(idone), 32'(exp_i));
    chk({tag, "_d_resp_cycle"}, 32'(ddone), 32'(exp_d));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    exp_t e;
    int   cyc;
    int   ni;
    int   ddone;

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ram_read", 32'(ram_read), 32'd0);
    chk("rst_ram_write", 32'(ram_write), 32'd0);
    chk("rst_ram_address", ram_address, 32'd0);
    chk("rst_ram_writedata", ram_writedata, 32'd0);
    chk("rst_i_waitrequest", 32'(i_waitrequest), 32'd1);
    chk("rst_d_waitrequest", 32'(d_waitrequest), 32'd1);
    chk("rst_i_readdata", i_readdata, 32'd0);
    chk("rst_d_readdata", d_readdata, 32'd0);
    chk("rst_errs", {30'd0, i_err, d_err}, 32'd0);
    rst_n = 1'b1;

    access(1'b1, 32'h10, 1'b0, 1'b1, 32'hDEADBEEF, "wr_10");
    access(1'b1, 32'h10, 1'b1, 1'b0, 32'h0, "rd_10");

    access(1'b1, 32'h0, 1'b0, 1'b1, 32'hA0A0A0A0, "wr_0");
    access(1'b1, 32'h4, 1'b0, 1'b1, 32'hB1B1B1B1, "wr_4");
    access(1'b1, 32'h8, 1'b0, 1'b1, 32'h11111111, "wr_8");

    do_reset();
    tie("tie1", 3, 6);
    tie("tie2", 3, 6);
    access(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, "ifetch_0");
    tie("tie3", 6, 3);

    // Continuous fetch stream with one data write arriving in cycle 2.
    e.err = 1'b0;
    e.data = model[0];
    repeat (4) iq.push_back(e);
    e.data = 32'd0;
    dq.push_back(e);
    model[8] = 32'hCAFEF00D;
    @(posedge clk); #1;
    i_address = 32'h0; i_read = 1'b1;
    cyc = 0; ni = 0; ddone = 0;
    while (ni < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (!i_waitrequest) ni++;
      if (!d_waitrequest) ddone = cyc;
      @(posedge clk); #1;
      if (cyc == 1) begin
        d_address = 32'h20; d_write = 1'b1; d_writedata = 32'hCAFEF00D;
      end
      if (ddone != 0) d_write = 1'b0;
      if (ni == 4) i_read = 1'b0;
    end
    chk("fetch_count", 32'(ni), 32'd4);
    chk("fetch_d_resp_cycle", 32'(ddone), 32'd6);
    access(1'b1, 32'h20, 1'b1, 1'b0, 32'h0, "rd_20");

    access(1'b1, 32'h3, 1'b1, 1'b0, 32'h0, "rd_misaligned");
    access(1'b1, 32'h2000, 1'b1, 1'b0, 32'h0, "rd_out_of_range");
    access(1'b1, 32'h2004, 1'b0, 1'b1, 32'h55555555, "wr_out_of_range");
    access(1'b0, 32'h2, 1'b0, 1'b0, 32'h0, "ifetch_misaligned");
    access(1'b1, 32'h1FFC, 1'b0, 1'b1, 32'h7E7E7E7E, "wr_top");
    access(1'b0, 32'h1FFC, 1'b0, 1'b0, 32'h0, "ifetch_top");
    access(1'b1, 32'h4, 1'b1, 1'b0, 32'h0, "rd_4_after_bad_wr");

    access(1'b1, 32'h40, 1'b1, 1'b1, 32'h12345678, "rdwr_40");
    access(1'b1, 32'h40, 1'b1, 1'b0, 32'h0, "rd_40");

    // Reset while the write to word 2 is in its ISSUE cycle.
    @(posedge clk); #1;
    d_address = 32'h8; d_write = 1'b1; d_writedata = 32'h22222222;
    @(negedge clk);
    @(negedge clk);
    chk("abort_issue_write", 32'(ram_write), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_ram_write", 32'(ram_write), 32'd0);
    chk("abort_d_waitrequest", 32'(d_waitrequest), 32'd1);
    chk("abort_ram_address", ram_address, 32'd0);
    d_write = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("abort_idle_strobes", {30'd0, ram_read, ram_write}, 32'd0);
      chk("abort_idle_wait", {30'd0, i_waitrequest, d_waitrequest}, 32'd3);
    end
    access(1'b1, 32'h8, 1'b1, 1'b0, 32'h0, "rd_8_after_abort");

    repeat (3) @(negedge clk);
    chk("iq_drained", 32'(iq.size()), 32'd0);
    chk("dq_drained", 32'(dq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
